// File: rtl/fa4_display_pkg.sv
// fa4_display_pkg: scan states, digit limit and blank pattern shared by the FA4 display scanner
package fa4_display_pkg;
  typedef enum logic {SCAN_OFF, SCAN_RUN} scan_state_t;
  localparam int MAX_DIGITS = 8;
  function automatic logic [7:0] seg_blank();
    return 8'h00;
  endfunction
endpackage

// File: rtl/hex_to_sevenseg.sv
// hex_to_sevenseg: combinational hex decoder; nibble in, active-high segments seg[6:0] = {g,f,e,d,c,b,a} out
module hex_to_sevenseg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
endmodule

// File: rtl/fa4_display_scanner.sv
// fa4_display_scanner: N-digit multiplexed hex display driver; clock/reset/enable, data_in/dp_in/blank_in/data_valid -> data_ready, display_sel, display, frame_done
module fa4_display_scanner
  import fa4_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int TICKS_PER_DIGIT = 500,
  parameter bit SEL_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [NUM_DIGITS-1:0]   display_sel,
  output logic [7:0]              display,
  output logic                    frame_done
);
  localparam int TW = TICKS_PER_DIGIT > 1 ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || TICKS_PER_DIGIT < 1) begin : g_bad_param
    $fatal(1, "fa4_display_scanner: NUM_DIGITS must be 1..8 and TICKS_PER_DIGIT >= 1");
  end
  scan_state_t state, state_next;
  logic [TW-1:0] tick;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] data_act, data_pend;
  logic [NUM_DIGITS-1:0] dp_act, dp_pend, blank_act, blank_pend;
  logic pending, run, dwell_end, wrap, commit, xfer;
  logic [3:0] nibble;
  logic [6:0] seg;
  assign data_ready = ~pending;
  // enable low blanks and rewinds in the same cycle, so the state register only delays the restart
  always_comb begin
    state_next = enable ? SCAN_RUN : SCAN_OFF;
    run = state == SCAN_RUN && enable;
    dwell_end = run && tick == TICK_LAST;
    wrap = dwell_end && idx == IDX_LAST;
    commit = pending && (wrap || !run);
    xfer = data_valid && !pending;
    nibble = data_act[{idx, 2'b00} +: 4];
  end
  hex_to_sevenseg u_dec (
    .nibble(nibble),
    .seg(seg)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= SCAN_OFF;
      tick <= '0;
      idx <= '0;
      data_act <= '0;
      dp_act <= '0;
      blank_act <= '0;
      data_pend <= '0;
      dp_pend <= '0;
      blank_pend <= '0;
      pending <= 1'b0;
      display <= seg_blank();
      display_sel <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      state <= state_next;
      tick <= !run || dwell_end ? '0 : tick + 1'b1;
      idx <= !run || wrap ? '0 : dwell_end ? idx + 1'b1 : idx;
      frame_done <= wrap;
      display_sel <= run ? SEL_OFF ^ (NUM_DIGITS'(1) << idx) : SEL_OFF;
      display <= run && !blank_act[idx] ? {dp_act[idx], seg} : seg_blank();
      pending <= commit ? 1'b0 : xfer ? 1'b1 : pending;
      if (commit) begin
        data_act <= data_pend;
        dp_act <= dp_pend;
        blank_act <= blank_pend;
      end
      if (xfer) begin
        data_pend <= data_in;
        dp_pend <= dp_in;
        blank_pend <= blank_in;
      end
    end
endmodule

// File: tb/tb_fa4_display_scanner.sv
// tb_fa4_display_scanner: randomized scoreboard bench against a frame-position reference model
module tb_fa4_display_scanner;
  localparam int N = 4;
  localparam int T = 3;
  localparam int CYCLES = 4000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, enable, data_valid, data_ready, frame_done;
  logic [15:0] data_in;
  logic [3:0] dp_in, blank_in, display_sel;
  logic [7:0] display;
  logic reset1, enable1, valid1, ready1, fd1;
  logic [3:0] data1;
  logic dp1, blank1, sel1;
  logic [7:0] disp1;
  fa4_display_scanner #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .SEL_ACTIVE_LOW(1'b0)) dut (
    .clock(clk), .reset(reset), .enable(enable), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .data_valid(data_valid), .data_ready(data_ready),
    .display_sel(display_sel), .display(display), .frame_done(frame_done)
  );
  fa4_display_scanner #(.NUM_DIGITS(1), .TICKS_PER_DIGIT(1), .SEL_ACTIVE_LOW(1'b0)) dut1 (
    .clock(clk), .reset(reset1), .enable(enable1), .data_in(data1), .dp_in(dp1),
    .blank_in(blank1), .data_valid(valid1), .data_ready(ready1),
    .display_sel(sel1), .display(disp1), .frame_done(fd1)
  );
  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] disp;
    logic fd;
    logic rdy;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit on;
  bit pend;
  int pos;
  logic [3:0] act_d [N];
  logic [3:0] pend_d [N];
  logic act_dp [N];
  logic pend_dp [N];
  logic act_bl [N];
  logic pend_bl [N];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  // the display position is the cycle count into the frame; the lit digit is pos / T
  task automatic model_step();
    exp_t e;
    bit xfer, do_commit;
    int d;
    e = '0;
    if (reset) begin
      on = 0;
      pos = 0;
      pend = 0;
      for (int i = 0; i < N; i++) begin
        act_d[i] = 0; act_dp[i] = 0; act_bl[i] = 0;
        pend_d[i] = 0; pend_dp[i] = 0; pend_bl[i] = 0;
      end
    end else begin
      xfer = data_valid && !pend;
      do_commit = 0;
      if (on && enable) begin
        d = pos / T;
        e.sel = 4'(1 << d);
        e.disp = act_bl[d] ? 8'h00 : {act_dp[d], seg_ref[act_d[d]]};
        e.fd = pos == N * T - 1;
        do_commit = e.fd && pend;
        pos = (pos + 1) % (N * T);
      end else begin
        pos = 0;
        do_commit = pend;
      end
      if (do_commit) begin
        for (int i = 0; i < N; i++) begin
          act_d[i] = pend_d[i]; act_dp[i] = pend_dp[i]; act_bl[i] = pend_bl[i];
        end
        pend = 0;
      end
      if (xfer) begin
        pend = 1;
        for (int i = 0; i < N; i++) begin
          pend_d[i] = data_in[4*i +: 4]; pend_dp[i] = dp_in[i]; pend_bl[i] = blank_in[i];
        end
      end
      on = enable;
    end
    e.rdy = !pend;
    q.push_back(e);
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    dp_in = '0;
    blank_in = '0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      reset = c < 2 || $urandom_range(0, 499) == 0;
      enable = enable ? $urandom_range(0, 99) >= 2 : $urandom_range(0, 9) < 3;
      if (!(data_valid && !data_ready)) begin
        data_valid = $urandom_range(0, 3) == 0;
        data_in = 16'($urandom);
        dp_in = 4'($urandom);
        blank_in = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      end
      model_step();
    end
    @(posedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sel", display_sel, e.sel);
      check("display", display, e.disp);
      check("frame_done", frame_done, e.fd);
      check("ready", data_ready, e.rdy);
    end
  end
  initial begin
    reset1 = 1'b1;
    enable1 = 1'b1;
    valid1 = 1'b1;
    data1 = 4'h7;
    dp1 = 1'b1;
    blank1 = 1'b0;
    repeat (2) @(negedge clk);
    reset1 = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("n1_frame_done", fd1, 1);
      check("n1_sel", sel1, 1);
      check("n1_display", disp1, 8'h87);
    end
  end
endmodule
